// File: rtl/quant_frame_sched_if.sv
// quant_frame_sched_if: input and output message handshakes of the frame re-quantizer.
interface quant_frame_sched_if #(
    parameter int INPUT_BIT  = 5,
    parameter int OUTPUT_BIT = 3,
    parameter int GROUP_NUM  = 3
);
    logic                            in_valid;
    logic                            in_ready;
    logic [GROUP_NUM*INPUT_BIT-1:0]  in_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [GROUP_NUM*OUTPUT_BIT-1:0] out_data;
    logic [1:0]                      out_shift;
    logic                            out_last;
    logic                            busy;
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_shift, out_last, busy
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_shift, out_last, busy
    );
endinterface

// File: rtl/quant_frame_sched.sv
// quant_frame_sched: buffers a frame of element-0-normalised LLR messages, picks one
// frame-wide shift from the overflow levels seen, then emits the frame requantised.
module quant_frame_sched #(
    parameter int INPUT_BIT  = 5,
    parameter int OUTPUT_BIT = 3,
    parameter int GROUP_NUM  = 3,
    parameter int FRAME_LEN  = 4
) (
    input logic clk,
    input logic rst,
    quant_frame_sched_if.slave bus
);
    localparam int W = INPUT_BIT;
    localparam int CW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_LOAD, S_DECIDE, S_EMIT} state_t;

    state_t        state;
    logic [CW-1:0] wcnt, rcnt;
    logic          fa, fb, fc;
    logic          out_valid;
    logic [1:0]    shift_q;
    logic [7:0]    s;
    logic [W:0]    mem  [FRAME_LEN][GROUP_NUM-1];
    logic [W:0]    n_in [GROUP_NUM-1];
    logic          fa_in, fb_in, fc_in;

    function automatic logic [OUTPUT_BIT-1:0] requant(input logic [W:0] n, input logic [7:0] sft);
        logic [W:0] t;
        t = n >> sft;
        return {n[W], t[OUTPUT_BIT-2:0]};
    endfunction

    // Differences are formed at W+1 bits so they can never overflow.
    always_comb begin
        for (int k = 1; k < GROUP_NUM; k++)
            n_in[k-1] = {bus.in_data[k*W+W-1], bus.in_data[k*W +: W]} - {bus.in_data[W-1], bus.in_data[W-1:0]};
    end

    always_comb begin
        fa_in = 1'b0;
        fb_in = 1'b0;
        fc_in = 1'b0;
        for (int k = 0; k < GROUP_NUM - 1; k++) begin
            fa_in = fa_in | (n_in[k][W] ^ n_in[k][W-1]);
            fb_in = fb_in | (n_in[k][W-1] ^ n_in[k][W-2]);
            fc_in = fc_in | (n_in[k][W-2] ^ n_in[k][W-3]);
        end
    end

    assign s = shift_q == 2'd3 ? 8'(W - OUTPUT_BIT + 1) :
               shift_q == 2'd2 ? 8'(W - OUTPUT_BIT) :
               shift_q == 2'd1 ? 8'(W - OUTPUT_BIT - 1) : 8'd0;

    always_comb begin
        bus.out_data = '0;
        for (int k = 1; k < GROUP_NUM; k++)
            bus.out_data[k*OUTPUT_BIT +: OUTPUT_BIT] = out_valid ? requant(mem[rcnt][k-1], s) : '0;
    end

    assign bus.in_ready  = state == S_LOAD && !rst;
    assign bus.out_valid = out_valid;
    assign bus.out_shift = shift_q;
    assign bus.out_last  = out_valid && rcnt == LAST;
    assign bus.busy      = state != S_LOAD;

    // The buffer needs no reset: counters and flags are what define an empty frame.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && bus.in_valid)
            for (int k = 0; k < GROUP_NUM - 1; k++) mem[wcnt][k] <= n_in[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            wcnt      <= '0;
            rcnt      <= '0;
            fa        <= 1'b0;
            fb        <= 1'b0;
            fc        <= 1'b0;
            out_valid <= 1'b0;
            shift_q   <= 2'd0;
        end else begin
            case (state)
                S_LOAD: if (bus.in_valid) begin
                    fa    <= fa | fa_in;
                    fb    <= fb | fb_in;
                    fc    <= fc | fc_in;
                    wcnt  <= wcnt == LAST ? '0 : wcnt + 1'b1;
                    state <= wcnt == LAST ? S_DECIDE : S_LOAD;
                end
                S_DECIDE: begin
                    shift_q   <= fa ? 2'd3 : fb ? 2'd2 : fc ? 2'd1 : 2'd0;
                    out_valid <= 1'b1;
                    state     <= S_EMIT;
                end
                S_EMIT: if (bus.out_ready) begin
                    rcnt <= rcnt == LAST ? '0 : rcnt + 1'b1;
                    if (rcnt == LAST) begin
                        fa        <= 1'b0;
                        fb        <= 1'b0;
                        fc        <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: doc/quant_frame_sched.md
Name: quant_frame_sched

Overview:
- Frame-level scheduler for the message re-quantizer in the NB-LDPC check-node path.
- Accepts FRAME_LEN messages of GROUP_NUM signed LLRs and normalises each message to its element 0.
- Buffers the normalised frame, picks one common shift for the whole frame from the overflow levels it saw, then emits the frame requantised to OUTPUT_BIT with that shift.
- Sits between the variable-node message producer and the PIM write-back stage. Uses valid/ready handshakes on both sides.

Parameters:
- INPUT_BIT, 5: width of each signed input LLR. Must be ≥ OUTPUT_BIT+2.
- OUTPUT_BIT, 3: width of each signed output LLR.
- GROUP_NUM, 3: LLRs per message. Must be ≥ 2.
- FRAME_LEN, 4: messages per frame. Must be ≥ 1.

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- RST, input, 1: asynchronous active-high reset.
- IN_VALID, input, 1: input message valid.
- IN_READY, output, 1: block accepts a message this cycle.
- IN_DATA, input, GROUP_NUM*INPUT_BIT: element k occupies bits [k*INPUT_BIT +: INPUT_BIT], two's complement.
- OUT_VALID, output, 1: output message valid.
- OUT_READY, input, 1: downstream accepts.
- OUT_DATA, output, GROUP_NUM*OUTPUT_BIT: element k occupies bits [k*OUTPUT_BIT +: OUTPUT_BIT].
- OUT_SHIFT, output, 2: frame shift code (3=A, 2=B, 1=C, 0=none). Stable for the whole EMIT phase.
- OUT_LAST, output, 1: high with the final message of a frame.
- BUSY, output, 1: high in DECIDE and EMIT.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=LOAD, write/read counters=0, flags A/B/C=0.
  - OUT_VALID=0, OUT_SHIFT=0, OUT_DATA=0, OUT_LAST=0, BUSY=0.
  - IN_READY=0 while RST is high.
- Normalisation, per accepted message:
  - N[k] = IN[k] - IN[0], computed at INPUT_BIT+1 bits signed, for k=1..GROUP_NUM-1.
  - N[0] is defined as 0 and is not stored.
  - Let W=INPUT_BIT. Per-element flags:
    - a = N[W] ^ N[W-1]
    - b = N[W-1] ^ N[W-2]
    - c = N[W-2] ^ N[W-3]
- Frame flags: FA/FB/FC are the OR of a/b/c over all elements of all messages accepted in the current frame.
- Shift selection, by priority:
  - FA: s = W-OUTPUT_BIT+1, code 3
  - else FB: s = W-OUTPUT_BIT, code 2
  - else FC: s = W-OUTPUT_BIT-1, code 1
  - else: s = 0, code 0
- Output element k≥1 = {N[k][W], N[k][s+OUTPUT_BIT-2 : s]}. Output element 0 = 0.
- Storage: register buffer of FRAME_LEN × (GROUP_NUM-1) × (INPUT_BIT+1) bits. No memory macro.
- State machine:
  - LOAD:
    - IN_READY=1. On IN_VALID&IN_READY, write N to buffer[wcnt], OR flags into FA/FB/FC, and increment wcnt.
    - When the accepted message has wcnt==FRAME_LEN-1, wcnt wraps to 0 and the next state is DECIDE.
  - DECIDE (exactly 1 cycle):
    - IN_READY=0. Register s and OUT_SHIFT from the flags (the flags include the final message). Go to EMIT.
  - EMIT:
    - OUT_VALID=1. OUT_DATA is driven from buffer[rcnt] with the latched s. OUT_LAST = (rcnt==FRAME_LEN-1).
    - On OUT_VALID&OUT_READY, rcnt increments.
    - On the last handshake: rcnt=0, FA/FB/FC cleared, OUT_VALID falls next cycle, state returns to LOAD.
- Latency: the final input is accepted at edge t. DECIDE occupies cycle t+1. OUT_VALID is first high in cycle t+2.
- Backpressure:
  - While OUT_READY=0, OUT_DATA, OUT_LAST and OUT_SHIFT hold and rcnt does not advance.
  - IN_READY stays 0 throughout DECIDE and EMIT. There is no overlap of frames.
- IN_VALID=0 in LOAD: no state change and no flag change. A partial frame waits indefinitely.
- FRAME_LEN=1: LOAD→DECIDE→EMIT for a single message, with OUT_LAST=1 on that message.
- Reset mid-frame: buffered data is discarded. After reset the block restarts in LOAD with an empty frame.
- Overflow: the subtraction cannot overflow at INPUT_BIT+1 bits. Output uses truncation, not saturation; the bits above s+OUTPUT_BIT-2 are dropped by design.

Test Plan (defaults: INPUT_BIT=5, OUTPUT_BIT=3, GROUP_NUM=3, FRAME_LEN=4):
- Zero frame: 4 messages {0,0,0} with OUT_READY=1 → OUT_SHIFT=0. Four outputs, each OUT_DATA=9'b0. OUT_LAST only on the 4th. First OUT_VALID 2 cycles after the 4th accept.
- C-level frame:
  - Input: messages {0,5,-6} and then {0,0,0}×3.
  - N1=5 (000101), N2=-6 (111010) → FC=1, s=1.
  - First output: element1=3'b010, element2=3'b101, so OUT_DATA=9'b101_010_000. OUT_SHIFT=1.
- A-level dominates:
  - Input: message {-16,15,0} and then {0,1,2}×3.
  - N1=31 → FA=1, s=3.
  - First output element1=3'b011. Remaining outputs are all-zero (N=1,2 truncate to 0). OUT_SHIFT=3.
- Backpressure: OUT_READY held low for 5 cycles during EMIT of message 2 → OUT_DATA stable and IN_READY=0 throughout. Remaining messages are delivered in order after release.
- Back-to-back frames: two frames sent with IN_VALID always high → IN_READY=0 from DECIDE until the cycle after the 4th output handshake. The second frame's shift is independent of the first (flags cleared): frame1 A-level, frame2 zeros → OUT_SHIFT=0.
- Async reset: RST pulsed between clock edges after 2 accepted inputs → outputs zero immediately. A fresh 4-message frame afterwards yields the correct results with no residue from the first two messages.
